// File: rtl/arduino_cmd_tx_if.sv
// Command handshake between game control and the Arduino command transmitter.
interface arduino_cmd_tx_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [4:0] cmd_payload;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_payload,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_payload,
        output cmd_ready
    );
endinterface

// File: rtl/arduino_cmd_tx.sv
// Serializes 7-bit commands plus odd parity to the Arduino over a clock/data/frame
// link, waits for its acknowledge and retries a bounded number of times.
module arduino_cmd_tx #(
    parameter int unsigned HALF_BIT    = 250,
    parameter int unsigned ACK_TIMEOUT = 50000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    arduino_cmd_tx_if.slave   cmd,
    output logic              ard_clk,
    output logic              ard_data,
    output logic              ard_frame,
    input  logic              ard_ack,
    output logic              tx_done,
    output logic              tx_err,
    output logic              busy
);

    localparam int unsigned HC_W = (HALF_BIT > 2)    ? $clog2(HALF_BIT)      : 1;
    localparam int unsigned TC_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT)   : 1;
    localparam int unsigned RT_W = (MAX_RETRY > 1)   ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [HC_W-1:0] HC_LAST   = HC_W'(HALF_BIT - 1);
    localparam logic [TC_W-1:0] TC_LAST   = TC_W'(ACK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RETRY_MAX = RT_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT_ACK,
        S_GAP,
        S_RELEASE
    } state_t;

    state_t          state, state_n;
    logic [HC_W-1:0] hcnt, hcnt_n;
    logic            phase, phase_n;
    logic [2:0]      bit_idx, bit_n;
    logic [TC_W-1:0] tcnt, tcnt_n;
    logic [RT_W-1:0] retry, retry_n;
    logic [7:0]      frame_q, frame_n;
    logic            clk_n, data_n, frame_o_n, done_n, err_n;
    logic            ack_meta, ack_s;
    logic            rdy_en;
    logic            ready_c;
    logic            accept_c;
    logic [7:0]      frame_new_c;

    // Two-flop synchronizer for the asynchronous Arduino acknowledge
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ard_ack;
            ack_s    <= ack_meta;
        end
    end

    // Holds cmd_ready low until the first edge after reset is released
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) rdy_en <= 1'b0;
        else       rdy_en <= 1'b1;
    end

    assign ready_c       = rdy_en & (state == S_IDLE) & ~ack_s;
    assign cmd.cmd_ready = ready_c;
    assign accept_c      = cmd.cmd_valid & ready_c;
    assign frame_new_c   = {cmd.cmd_op, cmd.cmd_payload, ~^{cmd.cmd_op, cmd.cmd_payload}};

    // Next-state and next-output logic; outputs are registered below
    always_comb begin
        state_n   = state;
        hcnt_n    = hcnt;
        phase_n   = phase;
        bit_n     = bit_idx;
        tcnt_n    = tcnt;
        retry_n   = retry;
        frame_n   = frame_q;
        clk_n     = ard_clk;
        data_n    = ard_data;
        frame_o_n = ard_frame;
        done_n    = 1'b0;
        err_n     = tx_err;

        case (state)
            S_IDLE: begin
                clk_n     = 1'b0;
                frame_o_n = 1'b0;
                if (accept_c) begin
                    state_n   = S_SHIFT;
                    frame_n   = frame_new_c;
                    hcnt_n    = '0;
                    phase_n   = 1'b0;
                    bit_n     = 3'd0;
                    retry_n   = '0;
                    err_n     = 1'b0;
                    frame_o_n = 1'b1;
                    data_n    = frame_new_c[7];
                end
            end

            S_SHIFT: begin
                if (hcnt == HC_LAST) begin
                    hcnt_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                        clk_n   = 1'b1;
                    end else if (bit_idx == 3'd7) begin
                        // Parity bit stays on ard_data while waiting for the ack
                        state_n = S_WAIT_ACK;
                        phase_n = 1'b0;
                        clk_n   = 1'b0;
                        tcnt_n  = '0;
                    end else begin
                        phase_n = 1'b0;
                        clk_n   = 1'b0;
                        bit_n   = bit_idx + 3'd1;
                        data_n  = frame_q[3'd6 - bit_idx];
                    end
                end else begin
                    hcnt_n = hcnt + HC_W'(1);
                end
            end

            S_WAIT_ACK: begin
                clk_n = 1'b0;
                if (ack_s) begin
                    state_n   = S_RELEASE;
                    done_n    = 1'b1;
                    frame_o_n = 1'b0;
                    retry_n   = '0;
                end else if (tcnt == TC_LAST) begin
                    frame_o_n = 1'b0;
                    if (retry == RETRY_MAX) begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = S_GAP;
                        hcnt_n  = '0;
                        retry_n = retry + RT_W'(1);
                    end
                end else begin
                    tcnt_n = tcnt + TC_W'(1);
                end
            end

            S_GAP: begin
                clk_n     = 1'b0;
                frame_o_n = 1'b0;
                if (hcnt == HC_LAST) begin
                    state_n   = S_SHIFT;
                    hcnt_n    = '0;
                    phase_n   = 1'b0;
                    bit_n     = 3'd0;
                    frame_o_n = 1'b1;
                    data_n    = frame_q[7];
                end else begin
                    hcnt_n = hcnt + HC_W'(1);
                end
            end

            S_RELEASE: begin
                clk_n     = 1'b0;
                frame_o_n = 1'b0;
                if (!ack_s) state_n = S_IDLE;
            end

            default: begin
                state_n   = S_IDLE;
                clk_n     = 1'b0;
                frame_o_n = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            hcnt      <= '0;
            phase     <= 1'b0;
            bit_idx   <= 3'd0;
            tcnt      <= '0;
            retry     <= '0;
            frame_q   <= 8'h00;
            ard_clk   <= 1'b0;
            ard_data  <= 1'b0;
            ard_frame <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            hcnt      <= hcnt_n;
            phase     <= phase_n;
            bit_idx   <= bit_n;
            tcnt      <= tcnt_n;
            retry     <= retry_n;
            frame_q   <= frame_n;
            ard_clk   <= clk_n;
            ard_data  <= data_n;
            ard_frame <= frame_o_n;
            tx_done   <= done_n;
            tx_err    <= err_n;
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_arduino_cmd_tx.sv
// Self-checking bench for arduino_cmd_tx with a frame scoreboard.
module tb_arduino_cmd_tx;

    localparam int unsigned HB = 2;
    localparam int unsigned TO = 10;
    localparam int unsigned MR = 2;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic ard_ack  = 1'b0;
    logic ard_clk, ard_data, ard_frame, tx_done, tx_err, busy;

    arduino_cmd_tx_if cif ();

    arduino_cmd_tx #(.HALF_BIT(HB), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .cmd       (cif),
        .ard_clk   (ard_clk),
        .ard_data  (ard_data),
        .ard_frame (ard_frame),
        .ard_ack   (ard_ack),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .busy      (busy)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         frames_seen = 0;
    int         done_cnt    = 0;
    int         bitcnt      = 0;
    logic       prev_clk    = 1'b0;
    logic [7:0] sh          = 8'h00;
    int         pos         = 0;
    int         wait_cyc    = 0;
    bit         accepted    = 1'b0;

    // Reference frame: 7 bits followed by a bit making the count of ones odd
    function automatic logic [7:0] model_frame(input logic [1:0] op, input logic [4:0] pl);
        logic [6:0] b;
        int ones;
        b = {op, pl};
        ones = 0;
        for (int i = 0; i < 7; i++) if (b[i]) ones++;
        return {b, ((ones % 2) == 0)};
    endfunction

    // Link monitor: collects bits on rising ard_clk and scores completed frames
    always @(negedge CLOCK_50) begin
        if (reset) begin
            bitcnt   = 0;
            prev_clk = 1'b0;
        end else begin
            if (!ard_frame) begin
                bitcnt = 0;
            end else if (ard_clk && !prev_clk) begin
                sh = {sh[6:0], ard_data};
                bitcnt++;
                if (bitcnt == 8) begin
                    bitcnt = 0;
                    frames_seen++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL frame_unexpected: got %02h expected none", sh);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (sh !== e) $display("FAIL frame_bits: got %02h expected %02h", sh, e);
                        else n_pass++;
                    end
                end
            end
            prev_clk = ard_clk;
            if (tx_done === 1'b1) done_cnt++;
        end
    end

    // Advance to the negedge of cycle n relative to the last accept
    task automatic skip_to(input int n);
        while (pos < n) begin
            @(posedge CLOCK_50);
            pos++;
        end
        @(negedge CLOCK_50);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] pl,
                            input logic [7:0] exp, input int copies);
        accepted = 1'b0;
        wait_cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK_50);
            if (cif.cmd_ready === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            wait_cyc++;
        end
        n_checks++;
        if (!accepted) begin
            $display("FAIL cmd_accept: got ready=0 expected ready=1 within 50 cycles");
        end else begin
            n_pass++;
            cif.cmd_valid   = 1'b1;
            cif.cmd_op      = op;
            cif.cmd_payload = pl;
            for (int c = 0; c < copies; c++) exp_q.push_back(exp);
            @(posedge CLOCK_50);
            #1;
            cif.cmd_valid   = 1'b0;
            cif.cmd_op      = 2'($urandom);
            cif.cmd_payload = 5'($urandom);
            pos = 0;
        end
    endtask

    task automatic test_reset();
        logic [1:0] op;
        logic [4:0] pl;
        int d0;
        @(negedge CLOCK_50);
        n_checks++;
        if ({cif.cmd_ready, ard_clk, ard_data, ard_frame, tx_done, tx_err, busy} !== 7'b0)
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {cif.cmd_ready, ard_clk, ard_data, ard_frame, tx_done, tx_err, busy});
        else n_pass++;
        reset = 1'b0;
        pos = 0;
        #1;
        n_checks++;
        if (cif.cmd_ready !== 1'b0) $display("FAIL ready_at_release: got %b expected 0", cif.cmd_ready);
        else n_pass++;
        skip_to(1);
        n_checks++;
        if (cif.cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", cif.cmd_ready);
        else n_pass++;

        op = 2'($urandom);
        pl = 5'($urandom);
        send_cmd(op, pl, model_frame(op, pl), 1);
        if (!accepted) return;
        skip_to(3);
        n_checks++;
        if ({ard_frame, ard_clk} !== 2'b11) $display("FAIL mid_shift: got %b expected 11", {ard_frame, ard_clk});
        else n_pass++;
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({ard_frame, ard_clk, busy, tx_err, cif.cmd_ready} !== 5'b0)
            $display("FAIL async_reset: got %b expected 00000", {ard_frame, ard_clk, busy, tx_err, cif.cmd_ready});
        else n_pass++;
        exp_q.delete();
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        pos = 0;
        skip_to(1);
        n_checks++;
        if ({cif.cmd_ready, busy, ard_frame} !== 3'b100 || done_cnt != d0)
            $display("FAIL after_mid_reset: got %b/%0d expected 100/%0d", {cif.cmd_ready, busy, ard_frame}, done_cnt, d0);
        else n_pass++;
    endtask

    task automatic test_single();
        int d0;
        bit ok;
        d0 = done_cnt;
        send_cmd(2'b01, 5'b00101, 8'h4A, 1);
        if (!accepted) return;
        skip_to(0);
        n_checks++;
        if ({ard_frame, ard_clk, ard_data, busy} !== 4'b1001)
            $display("FAIL first_bit: got %b expected 1001", {ard_frame, ard_clk, ard_data, busy});
        else n_pass++;
        skip_to(1);
        n_checks++;
        if (ard_clk !== 1'b0) $display("FAIL clk_low_half: got %b expected 0", ard_clk);
        else n_pass++;
        skip_to(2);
        n_checks++;
        if (ard_clk !== 1'b1) $display("FAIL clk_first_rise: got %b expected 1", ard_clk);
        else n_pass++;
        skip_to(32);
        n_checks++;
        if ({ard_frame, ard_clk, ard_data, busy} !== 4'b1001)
            $display("FAIL wait_ack_entry: got %b expected 1001", {ard_frame, ard_clk, ard_data, busy});
        else n_pass++;
        skip_to(35);
        ard_ack = 1'b1;
        skip_to(37);
        n_checks++;
        if (tx_done !== 1'b0) $display("FAIL done_early: got %b expected 0", tx_done);
        else n_pass++;
        skip_to(38);
        n_checks++;
        if ({tx_done, ard_frame} !== 2'b10) $display("FAIL done_pulse: got %b expected 10", {tx_done, ard_frame});
        else n_pass++;
        skip_to(39);
        ard_ack = 1'b0;
        n_checks++;
        if ({tx_done, busy} !== 2'b01) $display("FAIL done_one_cycle: got %b expected 01", {tx_done, busy});
        else n_pass++;
        skip_to(41);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_release: got %b expected 1", busy);
        else n_pass++;
        skip_to(42);
        n_checks++;
        if ({busy, tx_err} !== 2'b00 || done_cnt - d0 != 1 || exp_q.size() != 0)
            $display("FAIL single_end: got busy/err=%b done=%0d q=%0d expected 00/1/0", {busy, tx_err}, done_cnt - d0, exp_q.size());
        else n_pass++;
        ok = 1'b0;
    endtask

    task automatic test_parity();
        bit ok;
        send_cmd(2'b00, 5'b00000, 8'h01, 1);
        if (!accepted) return;
        skip_to(32);
        n_checks++;
        if (ard_data !== 1'b1) $display("FAIL parity_hold: got %b expected 1", ard_data);
        else n_pass++;
        skip_to(33);
        ard_ack = 1'b1;
        skip_to(36);
        n_checks++;
        if (tx_done !== 1'b1) $display("FAIL parity_done: got %b expected 1", tx_done);
        else n_pass++;
        ard_ack = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL parity_idle: got busy=1 expected 0 within 10 cycles");
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [4:0] pl;
        int k, d0, f0;
        bit ok;
        for (int n = 0; n < 4; n++) begin
            op = 2'($urandom);
            pl = 5'($urandom);
            k  = $urandom_range(0, 4);
            d0 = done_cnt;
            f0 = frames_seen;
            send_cmd(op, pl, model_frame(op, pl), 1);
            if (!accepted) return;
            if (n == 0) begin
                skip_to(10);
                ard_ack = 1'b1;
                skip_to(11);
                ard_ack = 1'b0;
                skip_to(31);
                n_checks++;
                if ({busy, ard_frame} !== 2'b11 || done_cnt != d0)
                    $display("FAIL ack_in_shift: got %b done=%0d expected 11 done=%0d", {busy, ard_frame}, done_cnt, d0);
                else n_pass++;
            end
            skip_to(32 + k);
            ard_ack = 1'b1;
            skip_to(35 + k);
            n_checks++;
            if (tx_done !== 1'b1) $display("FAIL rand_done: got %b expected 1 (k=%0d)", tx_done, k);
            else n_pass++;
            ard_ack = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge CLOCK_50);
                if (busy === 1'b0) begin ok = 1'b1; break; end
            end
            n_checks++;
            if (!ok || frames_seen - f0 != 1)
                $display("FAIL rand_end: got idle=%b frames=%0d expected 1/1", ok, frames_seen - f0);
            else n_pass++;
        end
    endtask

    task automatic test_retry();
        logic [1:0] op;
        logic [4:0] pl;
        logic [7:0] f;
        int d0;
        bit ok;
        op = 2'($urandom);
        pl = 5'($urandom);
        f  = model_frame(op, pl);
        d0 = done_cnt;
        send_cmd(op, pl, f, 2);
        if (!accepted) return;
        skip_to(41);
        n_checks++;
        if (ard_frame !== 1'b1) $display("FAIL retry_last_wait: got %b expected 1", ard_frame);
        else n_pass++;
        skip_to(42);
        n_checks++;
        if ({ard_frame, ard_clk} !== 2'b00) $display("FAIL gap_first: got %b expected 00", {ard_frame, ard_clk});
        else n_pass++;
        skip_to(43);
        n_checks++;
        if (ard_frame !== 1'b0) $display("FAIL gap_second: got %b expected 0", ard_frame);
        else n_pass++;
        skip_to(44);
        n_checks++;
        if ({ard_frame, ard_data} !== {1'b1, f[7]}) $display("FAIL resend_start: got %b expected %b", {ard_frame, ard_data}, {1'b1, f[7]});
        else n_pass++;
        skip_to(77);
        ard_ack = 1'b1;
        skip_to(80);
        n_checks++;
        if ({tx_done, tx_err} !== 2'b10) $display("FAIL retry_done: got %b expected 10", {tx_done, tx_err});
        else n_pass++;
        ard_ack = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || done_cnt - d0 != 1 || exp_q.size() != 0)
            $display("FAIL retry_end: got idle=%b done=%0d q=%0d expected 1/1/0", ok, done_cnt - d0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_exhaust();
        logic [1:0] op;
        logic [4:0] pl;
        int d0, f0;
        bit ok;
        op = 2'($urandom);
        pl = 5'($urandom);
        d0 = done_cnt;
        f0 = frames_seen;
        send_cmd(op, pl, model_frame(op, pl), 3);
        if (!accepted) return;
        skip_to(129);
        n_checks++;
        if ({busy, tx_err} !== 2'b10) $display("FAIL exhaust_last_wait: got %b expected 10", {busy, tx_err});
        else n_pass++;
        skip_to(130);
        n_checks++;
        if ({tx_err, busy, ard_frame, cif.cmd_ready} !== 4'b1001)
            $display("FAIL exhaust_err: got %b expected 1001", {tx_err, busy, ard_frame, cif.cmd_ready});
        else n_pass++;
        skip_to(140);
        n_checks++;
        if (tx_err !== 1'b1 || frames_seen - f0 != 3 || done_cnt != d0 || exp_q.size() != 0)
            $display("FAIL exhaust_sticky: got err=%b frames=%0d done=%0d expected 1/3/0", tx_err, frames_seen - f0, done_cnt - d0);
        else n_pass++;
        op = 2'($urandom);
        pl = 5'($urandom);
        send_cmd(op, pl, model_frame(op, pl), 1);
        if (!accepted) return;
        skip_to(0);
        n_checks++;
        if (tx_err !== 1'b0) $display("FAIL err_clear: got %b expected 0", tx_err);
        else n_pass++;
        skip_to(33);
        ard_ack = 1'b1;
        skip_to(36);
        ard_ack = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("FAIL exhaust_recover: got busy=1 expected 0 within 10 cycles");
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [4:0] pl;
        bit ok;
        op = 2'($urandom);
        pl = 5'($urandom);
        send_cmd(op, pl, model_frame(op, pl), 1);
        if (!accepted) return;
        skip_to(33);
        ard_ack = 1'b1;
        skip_to(36);
        ard_ack = 1'b0;
        op = 2'($urandom);
        pl = 5'($urandom);
        send_cmd(op, pl, model_frame(op, pl), 1);
        if (!accepted) return;
        n_checks++;
        if (wait_cyc != 2) $display("FAIL b2b_latency: got %0d expected 2", wait_cyc);
        else n_pass++;
        skip_to(0);
        n_checks++;
        if ({busy, ard_frame} !== 2'b11) $display("FAIL b2b_start: got %b expected 11", {busy, ard_frame});
        else n_pass++;
        skip_to(34);
        ard_ack = 1'b1;
        skip_to(37);
        n_checks++;
        if (tx_done !== 1'b1) $display("FAIL b2b_done: got %b expected 1", tx_done);
        else n_pass++;
        ard_ack = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || exp_q.size() != 0) $display("FAIL b2b_end: got idle=%b q=%0d expected 1/0", ok, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_stuck_ack();
        @(negedge CLOCK_50);
        ard_ack = 1'b1;
        pos = 0;
        skip_to(1);
        n_checks++;
        if (cif.cmd_ready !== 1'b1) $display("FAIL stuck_ready_1: got %b expected 1", cif.cmd_ready);
        else n_pass++;
        skip_to(2);
        n_checks++;
        if (cif.cmd_ready !== 1'b0) $display("FAIL stuck_ready_2: got %b expected 0", cif.cmd_ready);
        else n_pass++;
        cif.cmd_valid = 1'b1;
        skip_to(5);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stuck_no_accept: got %b expected 0", busy);
        else n_pass++;
        cif.cmd_valid = 1'b0;
        skip_to(6);
        ard_ack = 1'b0;
        skip_to(7);
        n_checks++;
        if (cif.cmd_ready !== 1'b0) $display("FAIL unstuck_ready_1: got %b expected 0", cif.cmd_ready);
        else n_pass++;
        skip_to(8);
        n_checks++;
        if (cif.cmd_ready !== 1'b1) $display("FAIL unstuck_ready_2: got %b expected 1", cif.cmd_ready);
        else n_pass++;
    endtask

    initial begin
        cif.cmd_valid   = 1'b0;
        cif.cmd_op      = 2'b00;
        cif.cmd_payload = 5'b00000;
        repeat (3) @(posedge CLOCK_50);
        test_reset();
        test_single();
        test_parity();
        test_random();
        test_retry();
        test_exhaust();
        test_back_to_back();
        test_stuck_ack();
        repeat (5) @(posedge CLOCK_50);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arduino_cmd_tx.md
# arduino_cmd_tx

Serial command transmitter from the FPGA to the Arduino sensor board; the opposite direction of the 3-bit box-address GPIO input path. It accepts 7-bit commands (op + payload) from game control through a valid/ready handshake. Each command is serialized MSB-first with odd parity over a clock/data/frame GPIO link, and the block waits for the Arduino's acknowledge. Missing acks are retried a bounded number of times before a sticky error flag is raised.

## Interface
- HALF_BIT, 250, CLOCK_50 cycles per half bit period (default gives 100 kHz ard_clk); minimum 2
- ACK_TIMEOUT, 50000, cycles allowed in WAIT_ACK before timeout (default 1 ms)
- MAX_RETRY, 2, retransmissions after the first attempt before error
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared immediately
- cmd_valid  in  1  command present
- cmd_op  in  2  00 PING, 01 SET_TARGET (payload[2:0]=box), 10 SCORE, 11 GAME_STATE
- cmd_payload  in  5  command payload
- cmd_ready  out  1  block can accept a command
- ard_clk  out  1  bit clock to Arduino; idles low
- ard_data  out  1  serial data
- ard_frame  out  1  high while a frame is in flight and awaiting ack
- ard_ack  in  1  Arduino acknowledge; asynchronous, 2-flop synchronized internally (ack_s)
- tx_done  out  1  one-cycle pulse on acknowledged frame
- tx_err  out  1  sticky; set on retry exhaustion, cleared on next accepted command
- busy  out  1  high in any state other than IDLE

## Operation
- Frame = {cmd_op, cmd_payload, p}: 8 bits, sent MSB first. p = ~^{cmd_op, cmd_payload}, so the total count of ones is odd.
- Op and payload are captured on acceptance (cmd_valid & cmd_ready). Later input changes do not affect the frame.
- cmd_ready = (state==IDLE) & ~ack_s. A stuck-high ack blocks new commands.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT -> WAIT_ACK after 8 bits.
  - WAIT_ACK -> RELEASE on ack_s; WAIT_ACK -> GAP on timeout with retries left; WAIT_ACK -> IDLE on timeout with retries exhausted.
  - GAP -> SHIFT after HALF_BIT cycles.
  - RELEASE -> IDLE when ack_s=0.
- SHIFT behaviour:
  - ard_frame=1.
  - Per bit: ard_data set to the bit, ard_clk=0 for HALF_BIT cycles, then ard_clk=1 for HALF_BIT cycles.
  - The Arduino samples on the rising ard_clk edge.
- WAIT_ACK behaviour:
  - ard_clk=0, ard_data holds the parity bit, ard_frame=1.
  - A timeout counter counts from 0 and times out when it reaches ACK_TIMEOUT-1 without ack_s.
- On ack_s in WAIT_ACK:
  - Next cycle: tx_done=1 for exactly one cycle, ard_frame=0, retry count cleared.
- GAP behaviour:
  - ard_frame=0, ard_clk=0 for HALF_BIT cycles. Retry count is incremented.
  - The same captured frame is resent.
- Retry exhaustion (timeout with retry count == MAX_RETRY):
  - tx_err=1, no tx_done pulse, ard_frame=0, return to IDLE.
- An ack_s arriving during SHIFT or GAP is ignored. It is only honoured in WAIT_ACK.
- Reset values: cmd_ready=0 while reset is asserted, then 1 (given ack_s=0) from the first cycle after reset deasserts; ard_clk=0, ard_data=0, ard_frame=0, tx_done=0, tx_err=0, busy=0, all counters 0, state IDLE.

## Timing
- Accept at cycle T:
  - T+1: ard_frame=1, ard_data=bit7, ard_clk=0.
  - ard_clk first rises at T+1+HALF_BIT.
- Bit k (0 = MSB) is driven from T+1+2k·HALF_BIT.
- The SHIFT phase is exactly 16·HALF_BIT cycles; WAIT_ACK begins at T+1+16·HALF_BIT.
- Ack latency: if ard_ack rises at cycle A (in WAIT_ACK), ack_s is high at A+2 and tx_done pulses at A+3.
- Back-to-back commands: earliest next accept is the cycle after ack_s is seen low in RELEASE.
- Reset mid-operation: outputs return to reset values asynchronously. The frame is abandoned and no tx_done is produced.

## Test plan
- Reset: assert reset mid-SHIFT (HALF_BIT=2). Required: ard_frame=0, ard_clk=0, busy=0, tx_err=0 immediately; cmd_ready=1 one cycle after release.
- Single frame (HALF_BIT=2): op=01, payload=00101.
  - Sampling ard_data on 8 rising ard_clk edges gives 0,1,0,0,1,0,1,0 (0x4A).
  - Ack at 3 cycles into WAIT_ACK gives one tx_done pulse; busy drops once ack is released.
- Parity: op=00, payload=00000 -> frame 0x01.
- Retry then success (ACK_TIMEOUT=10, MAX_RETRY=2): no ack on the first attempt.
  - Required: ard_frame low for 2 cycles, then an identical frame is resent.
  - Ack on the second attempt -> tx_done pulse, tx_err=0.
- Exhaustion: never ack. Required: 3 frames total, then tx_err=1 and no tx_done. The next accepted command clears tx_err.
- Stuck ack: hold ard_ack=1 while idle. Required: cmd_ready=0 from 2 cycles after it rises; cmd_ready=1 2 cycles after it falls.
